// File: rtl/phi_seq_pkg.sv
// -----------------------------------------------------------------------------
// phi_seq_pkg
// Shared definitions for the phi start-up / supervision sequencer:
//   - state codes and state width
//   - default parameter constants (reused by the top-level integration)
//   - small helpers for the overcurrent magnitude and the active-state decode
// -----------------------------------------------------------------------------
package phi_seq_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StIdle      = 3'd0,
    StPrecharge = 3'd1,
    StRamp      = 3'd2,
    StRun       = 3'd3,
    StFault     = 3'd4
  } state_e;

  localparam logic signed [31:0] PhiStartDefault        = 32'sd150;
  localparam int unsigned        PrechargeCyclesDefault = 1000;
  localparam int unsigned        RampDivDefault         = 500;
  localparam int unsigned        DeadtimeDefault        = 25;
  localparam logic signed [13:0] IMaxDefault            = 14'sd6000;
  localparam int unsigned        NumSwitches            = 4;

  // Magnitude of a 14-bit two's-complement sample. The most negative code has
  // no positive counterpart, so it saturates to the largest positive value.
  function automatic logic [13:0] abs_sat14(input logic signed [13:0] x);
    logic [13:0] mag;
    if (x == 14'sh2000) begin
      mag = 14'd8191;
    end else if (x[13]) begin
      mag = $unsigned(-x);
    end else begin
      mag = $unsigned(x);
    end
    return mag;
  endfunction

  // States in which the hybrid controller runs and its switches may conduct.
  function automatic logic is_active(input state_e st);
    return (st == StRamp) || (st == StRun);
  endfunction

endpackage

// File: rtl/deadtime_gate.sv
// -----------------------------------------------------------------------------
// deadtime_gate
// Per-switch turn-on delay for the MOSFET command bus. Each switch has its own
// saturating counter that runs while its command is high; the gated output is
// only asserted once the counter has reached DEADTIME, so a rising command
// appears DEADTIME+1 clocks later. Falling commands pass after one clock.
// All counters and outputs are cleared while enable is low.
//
// Ports:
//   clk     in  1  clock
//   rst     in  1  synchronous active-high reset
//   enable  in  1  switching permitted (controller in RAMP or RUN)
//   cmd     in  N  raw switch commands
//   gated   out N  registered, dead-time gated switch commands
// -----------------------------------------------------------------------------
module deadtime_gate #(
  parameter int unsigned N        = 4,
  parameter int unsigned DEADTIME = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] cmd,
  output logic [N-1:0] gated
);

  localparam int unsigned CntW = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEADTIME);

  logic [CntW-1:0] cnt_q [N];
  logic [N-1:0]    gated_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst || !enable || !cmd[k]) begin
        cnt_q[k]   <= '0;
        gated_q[k] <= 1'b0;
      end else begin
        if (cnt_q[k] != CntMax) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
        // Uses the pre-edge count, which adds the one extra clock of latency.
        gated_q[k] <= (cnt_q[k] == CntMax);
      end
    end
  end

  assign gated = gated_q;

endmodule

// File: rtl/phi_sequencer.sv
// -----------------------------------------------------------------------------
// phi_sequencer
// Start-up and supervision sequencer for the hybrid resonant-converter
// controller. Holds the controller in reset while the tank precharges, then
// slew-ramps phi from PHI_START to the commanded target (one degree every
// RAMP_DIV clocks) and keeps tracking it in RUN. Switch commands are gated with
// per-switch turn-on dead-time, and an overcurrent on |iC| latches a fault that
// forces every switch off until the fault is acknowledged with enable low.
//
// Ports:
//   i_clock        in  1   system clock
//   i_RESET        in  1   synchronous active-high reset
//   i_enable       in  1   run request (level)
//   i_fault_clear  in  1   fault acknowledge (level)
//   i_phi_target   in  32  signed target angle, degrees
//   i_iC           in  14  signed tank current sample
//   i_MOSFET_hc    in  4   switch commands from the hybrid controller
//   o_phi          out 32  signed angle to the hybrid controller
//   o_hc_RESET     out 1   active-low reset to the hybrid controller
//   o_MOSFET       out 4   dead-time gated switch commands
//   o_state        out 3   current state code
//   o_fault        out 1   latched overcurrent flag
// -----------------------------------------------------------------------------
module phi_sequencer
  import phi_seq_pkg::*;
#(
  parameter logic signed [31:0] PHI_START        = PhiStartDefault,
  parameter int unsigned        PRECHARGE_CYCLES = PrechargeCyclesDefault,
  parameter int unsigned        RAMP_DIV         = RampDivDefault,
  parameter int unsigned        DEADTIME         = DeadtimeDefault,
  parameter logic signed [13:0] I_MAX            = IMaxDefault
) (
  input  logic                            i_clock,
  input  logic                            i_RESET,
  input  logic                            i_enable,
  input  logic                            i_fault_clear,
  input  logic signed [31:0]              i_phi_target,
  input  logic signed [13:0]              i_iC,
  input  logic        [NumSwitches-1:0]   i_MOSFET_hc,
  output logic signed [31:0]              o_phi,
  output logic                            o_hc_RESET,
  output logic        [NumSwitches-1:0]   o_MOSFET,
  output logic        [StateWidth-1:0]    o_state,
  output logic                            o_fault
);

  // Terminal counts; both parameters are expected to be at least 1.
  localparam logic [31:0] PreLast  = 32'(PRECHARGE_CYCLES - 1);
  localparam logic [31:0] StepLast = 32'(RAMP_DIV - 1);
  localparam logic [13:0] IMaxMag  = $unsigned(I_MAX);

  state_e             state_q, state_d;
  logic [31:0]        cnt_q;
  logic signed [31:0] phi_q;
  logic               hc_reset_q;
  logic               fault_q;

  logic               over_current;
  logic               tracking;
  logic               at_target;
  logic               step_now;
  logic               gate_enable;
  logic signed [31:0] phi_step;

  assign over_current = (abs_sat14(i_iC) >= IMaxMag);
  assign tracking     = is_active(state_q);
  assign at_target    = (phi_q == i_phi_target);
  assign step_now     = tracking && !at_target && (cnt_q == StepLast);
  assign phi_step     = (i_phi_target > phi_q) ? (phi_q + 32'sd1) : (phi_q - 32'sd1);

  // Next state. Priority: reset, overcurrent, enable low, normal progression.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_enable) state_d = StPrecharge;
      end
      StPrecharge: begin
        if (over_current)             state_d = StFault;
        else if (!i_enable)           state_d = StIdle;
        else if (cnt_q == PreLast)    state_d = StRamp;
      end
      StRamp: begin
        if (over_current)             state_d = StFault;
        else if (!i_enable)           state_d = StIdle;
        else if (at_target)           state_d = StRun;
      end
      StRun: begin
        if (over_current)             state_d = StFault;
        else if (!i_enable)           state_d = StIdle;
      end
      StFault: begin
        if (i_fault_clear && !i_enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (i_RESET) state_d = StIdle;
  end

  // Driven from the next state so the switches drop on the same edge that
  // enters FAULT or IDLE rather than one clock later.
  assign gate_enable = is_active(state_d);

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      phi_q      <= PHI_START;
      hc_reset_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hc_reset_q <= gate_enable;
      fault_q    <= (state_d == StFault);

      // Cycle / step counter. While phi sits on the target no step is owed,
      // so the counter is held at zero and a new target gets a full
      // RAMP_DIV interval before its first step.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == StPrecharge) begin
        cnt_q <= cnt_q + 32'd1;
      end else if (tracking && !at_target && !step_now) begin
        cnt_q <= cnt_q + 32'd1;
      end else begin
        cnt_q <= '0;
      end

      if (!gate_enable) begin
        phi_q <= PHI_START;
      end else if (step_now) begin
        phi_q <= phi_step;
      end
    end
  end

  deadtime_gate #(
    .N        (NumSwitches),
    .DEADTIME (DEADTIME)
  ) u_deadtime_gate (
    .clk    (i_clock),
    .rst    (i_RESET),
    .enable (gate_enable),
    .cmd    (i_MOSFET_hc),
    .gated  (o_MOSFET)
  );

  assign o_phi      = phi_q;
  assign o_hc_RESET = hc_reset_q;
  assign o_state    = state_q;
  assign o_fault    = fault_q;

endmodule

// File: doc/phi_sequencer.md
# phi_sequencer

Start-up and supervision sequencer for the hybrid resonant-converter controller. It holds the controller in reset while the tank precharges, then slew-ramps the switching-surface angle `phi` from a safe start value to the commanded target, and keeps tracking that target under a slew limit. It also gates the controller's MOSFET commands with per-switch turn-on dead-time and latches an overcurrent fault that forces all switches off. It sits between the supervisory logic and the hybrid-control block: it drives that block's `phi` and active-low reset, and consumes its `o_MOSFET` bus.

## Interface
- `PHI_START`, 32'sd150, start angle (degrees, signed).
- `PRECHARGE_CYCLES`, 1000, clocks held in PRECHARGE.
- `RAMP_DIV`, 500, clocks per 1-degree phi step.
- `DEADTIME`, 25, turn-on delay in clocks per switch.
- `I_MAX`, 14'sd6000, overcurrent threshold on |iC|.

Ports:
- `i_clock`  in  1  system clock.
- `i_RESET`  in  1  reset, synchronous, active-high.
- `i_enable`  in  1  run request, level.
- `i_fault_clear`  in  1  fault acknowledge, level.
- `i_phi_target`  in  32  signed target angle in degrees.
- `i_iC`  in  14  signed tank current sample.
- `i_MOSFET_hc`  in  4  switch commands from the hybrid controller.
- `o_phi`  out  32  signed angle to the hybrid controller.
- `o_hc_RESET`  out  1  active-low reset to the hybrid controller.
- `o_MOSFET`  out  4  gated switch commands.
- `o_state`  out  3  current FSM state code.
- `o_fault`  out  1  latched overcurrent flag.

## Operation
- States: IDLE=0, PRECHARGE=1, RAMP=2, RUN=3, FAULT=4.
- Transition priority, highest first: `i_RESET`, overcurrent, `i_enable`=0, normal progression.

IDLE:
- Outputs: `o_phi`=PHI_START, `o_hc_RESET`=0, `o_MOSFET`=0.
- `i_enable`=1 moves to PRECHARGE and clears the cycle counter.

PRECHARGE:
- Outputs: `o_hc_RESET`=0, `o_MOSFET`=0.
- After PRECHARGE_CYCLES clocks in this state, move to RAMP.
- `i_enable`=0 returns to IDLE.

RAMP:
- `o_hc_RESET`=1; `o_MOSFET` comes from the dead-time gate.
- Every RAMP_DIV clocks, `o_phi` steps +1 or −1 toward `i_phi_target`.
- Move to RUN when `o_phi`==`i_phi_target`.
- If the target equals `o_phi` on entry, move to RUN after 1 clock.

RUN:
- Same output behaviour and stepping as RAMP.
- Target changes are tracked at the same slew rate without leaving RUN.

Overcurrent:
- Condition: |i_iC| ≥ I_MAX. |−8192| saturates to 8191.
- Checked in PRECHARGE, RAMP and RUN; any hit moves to FAULT.

FAULT:
- Outputs: `o_MOSFET`=0, `o_hc_RESET`=0, `o_fault`=1, `o_phi`=PHI_START.
- Exit to IDLE only when `i_fault_clear`=1 and `i_enable`=0 in the same cycle; `o_fault` clears on that exit.

Step counter:
- Resets on every state entry.
- Also resets when a step is taken.

Dead-time gate, independent per switch k:
- Counter `cnt_k` clears while `i_MOSFET_hc[k]`=0; otherwise it increments, saturating at DEADTIME.
- `o_MOSFET[k]` = `i_MOSFET_hc[k]` AND (`cnt_k`==DEADTIME).
- Falling edges pass through without delay.
- All counters clear outside RAMP/RUN.

Reset and width rules:
- `i_RESET`=1 forces IDLE on the next edge: `o_phi`=PHI_START, `o_hc_RESET`=0, `o_MOSFET`=0, `o_fault`=0, `o_state`=0. Reset is honoured in any state, including mid-ramp.
- `o_phi` arithmetic is 32-bit signed. No wrap is needed; the target range is −180..180, not checked.

## Timing
- All outputs are registered.
- A state change is visible 1 clock after the sampling edge of its cause.
- Overcurrent to `o_MOSFET`=0: 1 clock.
- Switch turn-on: `o_MOSFET[k]` rises DEADTIME+1 clocks after `i_MOSFET_hc[k]` rises (input held high).
- Switch turn-off: 1 clock after `i_MOSFET_hc[k]` falls.
- `o_hc_RESET` rises on the same edge that `o_state` becomes RAMP.
- The first phi step occurs RAMP_DIV clocks after RAMP entry.
- Overcurrent and `i_enable`=0 in the same cycle go to FAULT.
- `i_fault_clear` held with `i_enable`=1 keeps the block in FAULT.

## Structure
- Shared package `phi_seq_pkg` holds:
  - the state codes;
  - the 3-bit state width;
  - the default parameter constants, reused by the top-level integration.
- Sub-module `deadtime_gate` (parameters N=4, DEADTIME), instantiated once. Inputs: command bus, `enable` (=RAMP|RUN). Output: gated bus.
- The FSM, step counter, phi register and overcurrent compare live in `phi_sequencer`.

## Test plan
The bench uses PRECHARGE_CYCLES=10, RAMP_DIV=4, DEADTIME=3, PHI_START=150.

1. Start-up: `i_enable`=1 at t0, target=140.
   - Expected: PRECHARGE for 10 clocks, then RAMP with `o_hc_RESET`=1.
   - `o_phi` reaches 149 4 clocks after RAMP entry and steps down by 1 every 4 clocks to 140.
   - RUN is entered after the 10th step.
2. Dead-time: in RUN, `i_MOSFET_hc` goes 0000→1001 and is held.
   - Expected: `o_MOSFET`=1001 exactly 4 clocks later.
   - Dropping to 0000 gives `o_MOSFET`=0000 after 1 clock.
3. Overcurrent: in RUN, `i_iC`=−6000 for 1 cycle.
   - Expected next clock: `o_state`=4, `o_MOSFET`=0, `o_fault`=1, `o_hc_RESET`=0.
   - Also run `i_iC`=−8192 and check that it trips.
4. Fault exit: `i_fault_clear`=1 with `i_enable`=1.
   - Expected: stays in FAULT.
   - Then set `i_enable`=0, and IDLE is entered 1 clock later with `o_fault`=0.
5. Tracking in RUN: target changes 140→143.
   - Expected: `o_phi` is 141, 142, 143 at 4-clock intervals and `o_state` stays 3.
6. Reset mid-ramp: `i_RESET`=1 for 1 clock while `o_phi`=145.
   - Expected next clock: IDLE, `o_phi`=150, `o_MOSFET`=0, `o_hc_RESET`=0.
